relu_maxpool_121_2_16: RTL and testbench

- Stage directly downstream of conv_128_8_16_1.
- Consumes the convolution output stream in vectors of 121 signed 16-bit values (128 inputs, 8 taps, valid convolution).
- Applies ReLU to each value, then non-overlapping max-pooling with window 2.
- Emits 60 values per vector over the same valid/ready handshake.
- Feeds the next layer or the capture testbench.

---
 rtl/relu_maxpool_121_2_16.sv | 96 +++++++++
 tb/tb_relu_maxpool_121_2_16.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool_121_2_16.sv
// ReLU followed by non-overlapping max-pooling over fixed-length vectors from the conv stage.
// Pooled results go into a 2-entry output FIFO. The FIFO decouples x_ready from y_ready.
module relu_maxpool_121_2_16 #(
  parameter int T = 16,
  parameter int L = 121,
  parameter int W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] x_data,
  input  logic                x_valid,
  output logic                x_ready,
  output logic signed [T-1:0] y_data,
  output logic                y_valid,
  input  logic                y_ready
);

  localparam int P  = (L / W) * W;
  localparam int PW = (L > 1) ? $clog2(L) : 1;
  localparam int WW = (W > 1) ? $clog2(W) : 1;
  localparam logic [PW-1:0] POS_LAST = PW'(L - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(W - 1);

  logic [PW-1:0]       pos;
  logic [WW-1:0]       win;
  logic signed [T-1:0] acc;
  logic signed [T-1:0] mem [2];
  logic                rd_ptr;
  logic                wr_ptr;
  logic [1:0]          count;

  logic signed [T-1:0] v;
  logic signed [T-1:0] pooled;
  logic                accept;
  logic                in_pool;
  logic                push;
  logic                pop;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    v      = x_data[T-1] ? '0 : x_data;
    pooled = v;
    if (W > 1 && win != '0 && acc > v) pooled = acc;
  end

  // Samples past the last full window (pos >= P) are consumed but never pooled.
  assign accept  = x_valid && x_ready;
  assign in_pool = 32'(pos) < P;
  assign push    = accept && in_pool && (win == WIN_LAST);
  assign pop     = y_valid && y_ready;

  assign x_ready = (count < 2'd2) && !reset;
  assign y_valid = (count != 2'd0);
  assign y_data  = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos    <= '0;
      win    <= '0;
      acc    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      // NOTE: the FIFO storage is reset as well because y_data shows the head entry and must read 0 in reset.
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (accept) begin
        if (in_pool) begin
          acc <= pooled;
          win <= (win == WIN_LAST) ? '0 : win + 1'b1;
        end
        if (pos == POS_LAST) begin
          pos <= '0;
          win <= '0;
        end else begin
          pos <= pos + 1'b1;
        end
      end

      if (push) begin
        mem[wr_ptr] <= pooled;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;

      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_maxpool_121_2_16.sv
// Directed and randomised checks of relu_maxpool_121_2_16.
// Expected values come from hand formulas, or from a pairwise reference model for mixed data.
module tb_relu_maxpool_121_2_16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] x_data;
  logic        x_valid;
  logic        x_ready;
  logic [15:0] y_data;
  logic        y_valid;
  logic        y_ready;

  int tests = 0;
  int fails = 0;

  logic [15:0] in_q[$];
  logic [15:0] exp_q[$];

  relu_maxpool_121_2_16 dut (
    .clk     (clk),
    .reset   (reset),
    .x_data  (x_data),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .y_data  (y_data),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] relu(input logic [15:0] x);
    return x[15] ? 16'h0000 : x;
  endfunction

  // Pairwise reference for one 121-sample vector: max of each (2n, 2n+1) pair; sample 120 is dropped.
  task automatic model_vector(input logic [15:0] vec[121]);
    logic [15:0] a;
    logic [15:0] b;
    for (int n = 0; n < 60; n++) begin
      a = relu(vec[2*n]);
      b = relu(vec[2*n+1]);
      exp_q.push_back((a > b) ? a : b);
    end
  endtask

  // Streams in_q into the DUT while checking every output transfer against exp_q.
  task automatic run_stream(input int vprob, input int rprob, input int hold, input int budget,
                            output int held, output int xr_low);
    int cyc = 0;
    int idx = 0;
    held   = 0;
    xr_low = 0;
    while ((idx < in_q.size() || exp_q.size() > 0) && cyc < budget) begin
      @(negedge clk);
      x_valid = (idx < in_q.size()) && ($urandom_range(99) < vprob);
      x_data  = x_valid ? in_q[idx] : 16'h0000;
      y_ready = (cyc >= hold) && ($urandom_range(99) < rprob);
      #1;
      if (x_valid && !x_ready) xr_low++;
      if (x_valid && x_ready) begin
        idx++;
        if (cyc < hold) held++;
      end
      if (y_valid && y_ready) begin
        if (exp_q.size() == 0) check("extra_output", {16'h0, y_data}, 32'hffff_ffff);
        else check("y_data", {16'h0, y_data}, {16'h0, exp_q.pop_front()});
      end
      cyc++;
    end
    check("stream_complete", {31'h0, (idx == in_q.size()) && (exp_q.size() == 0)}, 32'd1);
    @(negedge clk);
    x_valid = 1'b0;
    y_ready = 1'b0;
    in_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] vec[121];
    int held;
    int xr_low;

    reset   = 1'b1;
    x_valid = 1'b0;
    x_data  = 16'h0;
    y_ready = 1'b0;

    // Reset state
    #12;
    check("rst_y_valid", {31'h0, y_valid}, 32'd0);
    check("rst_x_ready", {31'h0, x_ready}, 32'd0);
    check("rst_y_data", {16'h0, y_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_x_ready", {31'h0, x_ready}, 32'd1);
    check("post_rst_y_valid", {31'h0, y_valid}, 32'd0);

    // First-output latency: y_valid rises right after the edge accepting sample 1
    @(negedge clk);
    x_valid = 1'b1;
    x_data  = 16'd5;
    @(posedge clk);
    #1;
    check("lat_after_s0", {31'h0, y_valid}, 32'd0);
    @(negedge clk);
    x_data = 16'hFFFD;
    @(posedge clk);
    #1;
    check("lat_after_s1_valid", {31'h0, y_valid}, 32'd1);
    check("lat_after_s1_data", {16'h0, y_data}, 32'd5);
    @(negedge clk);
    x_valid = 1'b0;
    y_ready = 1'b1;
    @(posedge clk);
    #1;
    check("lat_drained", {31'h0, y_valid}, 32'd0);
    @(negedge clk);
    y_ready = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Ramp 0..120: outputs 1,3,...,119; ready never drops
    for (int k = 0; k < 121; k++) in_q.push_back(16'(k));
    for (int n = 0; n < 60; n++) exp_q.push_back(16'(2*n + 1));
    run_stream(100, 100, 0, 1000, held, xr_low);
    check("ramp_x_ready_low_cycles", xr_low, 32'd0);
    #1;
    check("ramp_idle_y_valid", {31'h0, y_valid}, 32'd0);

    // All -10: every output is 0
    for (int k = 0; k < 121; k++) in_q.push_back(16'hFFF6);
    for (int n = 0; n < 60; n++) exp_q.push_back(16'h0000);
    run_stream(100, 100, 0, 1000, held, xr_low);

    // Sign and extreme-value corner pairs, then a ramp
    vec[0] = 16'hFFFB; vec[1] = 16'd3;
    vec[2] = 16'd7;    vec[3] = 16'hFFFE;
    vec[4] = 16'hFFFF; vec[5] = 16'hFFFF;
    vec[6] = 16'h7FFF; vec[7] = 16'h7FFE;
    vec[8] = 16'h8000; vec[9] = 16'h0000;
    for (int k = 10; k < 121; k++) vec[k] = 16'(k);
    for (int k = 0; k < 121; k++) in_q.push_back(vec[k]);
    exp_q.push_back(16'd3);
    exp_q.push_back(16'd7);
    exp_q.push_back(16'd0);
    exp_q.push_back(16'h7FFF);
    exp_q.push_back(16'd0);
    for (int n = 5; n < 60; n++) exp_q.push_back(16'(2*n + 1));
    run_stream(100, 100, 0, 1000, held, xr_low);

    // Backpressure: y_ready low for 20 cycles, only 4 samples fit before x_ready drops
    for (int k = 0; k < 121; k++) vec[k] = (k % 4 == 1) ? 16'(-k) : 16'(3*k + 1);
    for (int k = 0; k < 121; k++) in_q.push_back(vec[k]);
    model_vector(vec);
    run_stream(100, 100, 20, 2000, held, xr_low);
    check("bp_accepted_during_stall", held, 32'd4);
    check("bp_x_ready_dropped", {31'h0, xr_low > 0}, 32'd1);

    // Back-to-back vectors: windows restart at the vector boundary
    for (int k = 0; k < 121; k++) in_q.push_back(16'(k));
    for (int k = 0; k < 121; k++) in_q.push_back(16'(1000 + k));
    for (int n = 0; n < 60; n++) exp_q.push_back(16'(2*n + 1));
    for (int n = 0; n < 60; n++) exp_q.push_back(16'(1000 + 2*n + 1));
    run_stream(100, 100, 0, 2000, held, xr_low);

    // Random data and handshakes over 78 vectors
    for (int v = 0; v < 78; v++) begin
      for (int k = 0; k < 121; k++) vec[k] = 16'($urandom_range(65535));
      for (int k = 0; k < 121; k++) in_q.push_back(vec[k]);
      model_vector(vec);
    end
    run_stream(75, 75, 0, 40000, held, xr_low);

    // Asynchronous reset after input 37, then a fresh vector pools from pos 0
    for (int k = 0; k < 37; k++) in_q.push_back(16'(k));
    for (int n = 0; n < 18; n++) exp_q.push_back(16'(2*n + 1));
    run_stream(100, 100, 0, 1000, held, xr_low);
    x_valid = 1'b1;
    x_data  = 16'd37;
    y_ready = 1'b0;
    #1;
    check("pre_rst_x_ready", {31'h0, x_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("pre_rst_y_valid", {31'h0, y_valid}, 32'd1);
    check("pre_rst_y_data", {16'h0, y_data}, 32'd37);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_y_valid", {31'h0, y_valid}, 32'd0);
    check("async_rst_x_ready", {31'h0, x_ready}, 32'd0);
    check("async_rst_y_data", {16'h0, y_data}, 32'd0);
    @(negedge clk);
    x_valid = 1'b0;
    reset   = 1'b0;
    for (int k = 0; k < 121; k++) in_q.push_back(16'(500 + k));
    for (int n = 0; n < 60; n++) exp_q.push_back(16'(500 + 2*n + 1));
    run_stream(100, 100, 0, 1000, held, xr_low);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
